// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, steps FETCH/EXEC/
// MEM_WAIT/WB and drives stage enables plus a start/done handshake.
//
// Ports:
//   Clk, Reset (async, active-high)
//   Start, StartAddr        : begin a run at StartAddr (IDLE or DONE only)
//   Instr                   : combinational ROM data at Pc
//   BranchTaken/Target      : datapath branch result, sampled in EXEC
//   MemAck                  : data memory completion, sampled in MEM_WAIT
//   Pc, InstrReg            : current address and latched instruction
//   ExecEn, MemReq, WbEn    : per-stage strobes (Moore, from state)
//   Busy, Done, Error       : run status
//   RetiredCnt              : saturating retired-instruction count
module instr_sequencer #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'b111_11_0000,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  input  logic               MemAck,
  output logic [PC_W-1:0]    Pc,
  output logic [INSTR_W-1:0] InstrReg,
  output logic               ExecEn,
  output logic               MemReq,
  output logic               WbEn,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [CNT_W-1:0]   RetiredCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_WB,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               brt_q, brt_d;
  logic [PC_W-1:0]    btgt_q, btgt_d;
  logic [7:0]         tmo_q, tmo_d;

  logic [2:0] opcode;
  logic       is_mem;
  logic       is_halt;

  assign opcode  = ir_q[INSTR_W-1 -: 3];
  assign is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_halt = (ir_q == HALT_INSTR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      brt_q   <= 1'b0;
      btgt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      brt_q   <= brt_d;
      btgt_q  <= btgt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    brt_d   = brt_q;
    btgt_d  = btgt_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = Instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        brt_d  = BranchTaken;
        btgt_d = BranchTarget;
        if (is_halt) begin
          state_d = S_DONE;
        end else if (is_mem) begin
          tmo_d   = '0;
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_WAIT: begin
        // An ack on the final allowed cycle still completes the access.
        if (MemAck) begin
          state_d = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        pc_d = brt_q ? btgt_q : pc_q + PC_W'(1);
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Pc         = pc_q;
  assign InstrReg   = ir_q;
  assign RetiredCnt = cnt_q;
  assign Error      = err_q;
  assign ExecEn     = (state_q == S_EXEC);
  assign MemReq     = (state_q == S_MEM_WAIT);
  assign WbEn       = (state_q == S_WB);
  assign Done       = (state_q == S_DONE);
  assign Busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
